// File: rtl/mode_switch_sequencer.sv
// mode_switch_sequencer: debounces a raw board switch, rejects illegal codes
// and applies the requested ADC mode break-before-make (drain the active
// converter, hold mode_select at 000 for a settle period, then apply).
module mode_switch_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SETTLE_CYCLES   = 1000,
    parameter int DRAIN_TIMEOUT   = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] mode_request,
    input  logic       conv_busy,
    output logic [2:0] mode_select,
    output logic       ready,
    output logic       switching,
    output logic       drain_timeout,
    output logic       bad_request
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (SETTLE_CYCLES > DRAIN_TIMEOUT) ? SETTLE_CYCLES : DRAIN_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_MAX     = DW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] DRAIN_LAST  = TW'(DRAIN_TIMEOUT - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // Only OFF and the three one-hot modes may ever reach the decoder.
    function automatic logic is_legal(input logic [2:0] code);
        return (code == 3'b000) || (code == 3'b001) ||
               (code == 3'b010) || (code == 3'b100);
    endfunction

    // Input path state
    logic [2:0]    sync1_q, sync1_d;
    logic [2:0]    sync2_q, sync2_d;
    logic [2:0]    prev_q, prev_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          accept;
    logic [2:0]    target_q, target_d;
    logic          bad_q, bad_d;

    // Sequencer state
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    current_q, current_d;
    logic [2:0]    mode_select_q, mode_select_d;

    // Synchronizer, debounce counter and request acceptance.
    always_comb begin
        sync1_d   = mode_request;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        deb_cnt_d = deb_cnt_q;
        accept    = 1'b0;
        target_d  = target_q;
        bad_d     = 1'b0;
        if (sync2_q != prev_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q != DEB_MAX) begin
            // Saturation makes acceptance fire exactly once per stable run.
            deb_cnt_d = deb_cnt_q + DW'(1);
            accept    = (deb_cnt_q == DEB_LAST);
        end
        if (accept) begin
            if (is_legal(sync2_q)) begin
                target_d = sync2_q;
            end else begin
                bad_d = 1'b1;
            end
        end
    end

    // State register: all flops, asynchronously cleared to the OFF/ACTIVE state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q       <= 3'b000;
            sync2_q       <= 3'b000;
            prev_q        <= 3'b000;
            deb_cnt_q     <= '0;
            target_q      <= 3'b000;
            bad_q         <= 1'b0;
            state_q       <= ST_ACTIVE;
            timer_q       <= '0;
            current_q     <= 3'b000;
            mode_select_q <= 3'b000;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            deb_cnt_q     <= deb_cnt_d;
            target_q      <= target_d;
            bad_q         <= bad_d;
            state_q       <= state_d;
            timer_q       <= timer_d;
            current_q     <= current_d;
            mode_select_q <= mode_select_d;
        end
    end

    // Next-state logic: ACTIVE -> (DRAIN) -> SETTLE -> ACTIVE, with DRAIN revert.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        current_d = current_q;
        case (state_q)
            ST_ACTIVE: begin
                if (target_q != current_q) begin
                    timer_d = '0;
                    // From OFF there is no converter to drain.
                    state_d = (current_q != 3'b000) ? ST_DRAIN : ST_SETTLE;
                end
            end
            ST_DRAIN: begin
                if (target_q == current_q) begin
                    // Request reverted: keep the running mode, no OFF gap.
                    state_d = ST_ACTIVE;
                    timer_d = '0;
                end else if (!conv_busy || (timer_q == DRAIN_LAST)) begin
                    state_d = ST_SETTLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    // Latest target wins, even if it changed while settling.
                    current_d = target_q;
                    state_d   = ST_ACTIVE;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_ACTIVE;
                timer_d = '0;
            end
        endcase
    end

    // Outputs: status from the current state; mode_select registered so it
    // lines up with the state it belongs to (000 for every SETTLE cycle).
    always_comb begin
        ready         = (state_q == ST_ACTIVE);
        switching     = (state_q == ST_DRAIN) || (state_q == ST_SETTLE);
        drain_timeout = (state_q == ST_DRAIN) && (target_q != current_q) &&
                        conv_busy && (timer_q == DRAIN_LAST);
        mode_select_d = (state_d == ST_SETTLE) ? 3'b000 : current_d;
    end

    assign mode_select = mode_select_q;
    assign bad_request = bad_q;

    // Decoder must only ever see OFF or a single mode.
    a_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(mode_select));

    // No direct hop between two different non-zero modes.
    a_bbm: assert property (@(posedge clk) disable iff (reset)
        ((mode_select != $past(mode_select)) && ($past(mode_select) != 3'b000))
        |-> (mode_select == 3'b000));

endmodule

// File: tb/tb_mode_switch_sequencer.sv
// Directed bench for mode_switch_sequencer (DEBOUNCE=4, SETTLE=8, DRAIN=16).
// Cycle i below means the negedge after the i-th posedge since the last stimulus change.
module tb_mode_switch_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] mode_request = 3'b000;
    logic       conv_busy = 1'b0;
    logic [2:0] mode_select;
    logic       ready;
    logic       switching;
    logic       drain_timeout;
    logic       bad_request;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mode_switch_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .SETTLE_CYCLES  (8),
        .DRAIN_TIMEOUT  (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mode_request (mode_request),
        .conv_busy    (conv_busy),
        .mode_select  (mode_select),
        .ready        (ready),
        .switching    (switching),
        .drain_timeout(drain_timeout),
        .bad_request  (bad_request)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {mode_select, ready, switching, drain_timeout, bad_request}
    function automatic logic [6:0] pack(input logic [2:0] m, input logic r, input logic s,
                                        input logic d, input logic b);
        return {m, r, s, d, b};
    endfunction

    function automatic logic [6:0] obs_v();
        return {mode_select, ready, switching, drain_timeout, bad_request};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset (checked asynchronously), then hold code: accepted at cycle 7,
    // SETTLE during cycles 8..15, mode applied from cycle 16.
    task automatic bring_up(input logic [2:0] code, input int ncyc);
        logic sw;
        reset        = 1'b1;
        mode_request = code;
        conv_busy    = 1'b0;
        #1 chk("reset_state", obs_v(), pack(3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= ncyc; i++) begin
            step();
            sw = (i >= 8) && (i <= 15);
            chk($sformatf("up%0h_c%0d", code, i), obs_v(),
                pack((i >= 16) ? code : 3'b000, !sw, sw, 1'b0, 1'b0));
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        @(negedge clk);

        // 1: power-up into PWM
        bring_up(3'b010, 20);

        // 2: PWM -> R2R, busy drops after 5 DRAIN cycles
        conv_busy    = 1'b1;
        mode_request = 3'b100;
        for (int i = 1; i <= 22; i++) begin
            step();
            if (i <= 7)       chk($sformatf("drain_c%0d", i), obs_v(), pack(3'b010, 1, 0, 0, 0));
            else if (i <= 12) chk($sformatf("drain_c%0d", i), obs_v(), pack(3'b010, 0, 1, 0, 0));
            else if (i <= 20) chk($sformatf("drain_c%0d", i), obs_v(), pack(3'b000, 0, 1, 0, 0));
            else              chk($sformatf("drain_c%0d", i), obs_v(), pack(3'b100, 1, 0, 0, 0));
            if (i == 12) conv_busy = 1'b0;
        end

        // 3: XADC -> PWM with busy stuck: timeout on 16th DRAIN cycle
        bring_up(3'b001, 18);
        conv_busy    = 1'b1;
        mode_request = 3'b010;
        for (int i = 1; i <= 34; i++) begin
            step();
            if (i <= 7)       chk($sformatf("tmo_c%0d", i), obs_v(), pack(3'b001, 1, 0, 0, 0));
            else if (i <= 23) chk($sformatf("tmo_c%0d", i), obs_v(), pack(3'b001, 0, 1, i == 23, 0));
            else if (i <= 31) chk($sformatf("tmo_c%0d", i), obs_v(), pack(3'b000, 0, 1, 0, 0));
            else              chk($sformatf("tmo_c%0d", i), obs_v(), pack(3'b010, 1, 0, 0, 0));
        end

        // 4: glitchy switch around XADC never accepted
        bring_up(3'b001, 18);
        for (int i = 0; i < 52; i++) begin
            if (i < 40) mode_request = ((i / 2) % 2 == 1) ? 3'b001 : 3'b010;
            else        mode_request = 3'b001;
            step();
            chk($sformatf("glitch_c%0d", i), obs_v(), pack(3'b001, 1, 0, 0, 0));
        end

        // 5a: illegal 110 while in XADC
        mode_request = 3'b110;
        for (int i = 1; i <= 14; i++) begin
            step();
            chk($sformatf("bad_c%0d", i), obs_v(), pack(3'b001, 1, 0, 0, i == 7));
        end

        // 5b: illegal 101 during DRAIN leaves target at PWM
        conv_busy    = 1'b1;
        mode_request = 3'b010;
        for (int i = 1; i <= 34; i++) begin
            step();
            if (i <= 7)       chk($sformatf("bad_dr_c%0d", i), obs_v(), pack(3'b001, 1, 0, 0, 0));
            else if (i <= 23) chk($sformatf("bad_dr_c%0d", i), obs_v(), pack(3'b001, 0, 1, i == 23, i == 16));
            else if (i <= 31) chk($sformatf("bad_dr_c%0d", i), obs_v(), pack(3'b000, 0, 1, 0, 0));
            else              chk($sformatf("bad_dr_c%0d", i), obs_v(), pack(3'b010, 1, 0, 0, 0));
            if (i == 9) mode_request = 3'b101;
        end

        // 6a: request reverts to PWM during DRAIN -> back to ACTIVE, no OFF gap
        conv_busy    = 1'b1;
        mode_request = 3'b100;
        for (int i = 1; i <= 24; i++) begin
            step();
            if (i <= 7)       chk($sformatf("revert_c%0d", i), obs_v(), pack(3'b010, 1, 0, 0, 0));
            else if (i <= 17) chk($sformatf("revert_c%0d", i), obs_v(), pack(3'b010, 0, 1, 0, 0));
            else              chk($sformatf("revert_c%0d", i), obs_v(), pack(3'b010, 1, 0, 0, 0));
            if (i == 10) mode_request = 3'b010;
        end

        // 6b: reset mid-SETTLE, then a clean restart with the switch held
        bring_up(3'b100, 10);
        bring_up(3'b100, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mode_switch_sequencer.md
Name: mode_switch_sequencer

Overview:
- Sequences the ADC mode selection; drives the 3-bit one-hot mode_select consumed by the output decoder.
- Debounces raw board switch requests and rejects illegal codes.
- Performs break-before-make switching: drains the active converter, holds OFF for a settle period, then applies the new mode.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles of the synchronized request before it is accepted (>=1)
SETTLE_CYCLES, 1000, cycles mode_select is held at 000 between modes (>=1)
DRAIN_TIMEOUT, 100000, maximum cycles to wait for conv_busy to clear before forcing the switch (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
mode_request  input  3  raw switch request (000 OFF, 001 XADC, 010 PWM, 100 R2R), asynchronous to clk
conv_busy  input  1  active converter mid-conversion; synchronous to clk
mode_select  output  3  one-hot mode to decoder; only 000/001/010/100 ever driven
ready  output  1  high in ACTIVE state (mode_select stable and valid)
switching  output  1  high in DRAIN or SETTLE
drain_timeout  output  1  one-cycle pulse when DRAIN exits on timeout
bad_request  output  1  one-cycle pulse when an illegal code becomes debounced-stable

Behaviour:
- Reset (async assert, sync deassert use): mode_select=000, current=000, target=000, state ACTIVE, ready=1, switching=0, pulses=0, counters=0, synchronizer flops=000.
- Input path: mode_request -> 2-flop synchronizer -> sync_req. Debounce counter clears whenever sync_req differs from previous-cycle sync_req. Otherwise it increments, saturating at DEBOUNCE_CYCLES. On the cycle the count reaches DEBOUNCE_CYCLES, sync_req is accepted once.
- Accepting the same code again requires a change and re-stabilization.
- Accepted legal code -> target <= code. Accepted illegal code (011,101,110,111) -> bad_request pulse next cycle; target unchanged.
- States:
  - ACTIVE:
    - mode_select=current, ready=1.
    - If target != current: current != 000 -> DRAIN; current == 000 -> SETTLE (nothing to drain).
  - DRAIN:
    - mode_select=current, ready=0, switching=1. Timer counts from 0.
    - target == current (request reverted): -> ACTIVE, no OFF period, no pulse.
    - Else conv_busy==0: -> SETTLE.
    - Else timer reaches DRAIN_TIMEOUT-1: drain_timeout pulse, -> SETTLE.
    - Revert check has priority over busy/timeout in the same cycle.
  - SETTLE:
    - mode_select=000, switching=1, ready=0. Counter counts SETTLE_CYCLES cycles (first SETTLE cycle is count 0).
    - Target changes during SETTLE do not restart the count.
    - At expiry: current <= target (latest value, may be 000), -> ACTIVE. New mode_select appears the cycle after the last SETTLE cycle.
    - If target==000 at expiry, ACTIVE with 000.
- mode_select is registered. It never transitions directly between two different non-zero codes; every change between non-zero modes passes through at least SETTLE_CYCLES of 000.
- Target changes in ACTIVE while conv_busy=1 never alter mode_select before conv_busy drops or timeout.
- Reset asserted mid-DRAIN/SETTLE: immediate return to reset values; mode_select=000 asynchronously.
- Post-reset: switch position must be re-debounced before any mode is applied. If the switch is held at a legal non-zero code, it is applied after sync + DEBOUNCE_CYCLES + SETTLE_CYCLES.

Test Plan:
(Params DEBOUNCE_CYCLES=4, SETTLE_CYCLES=8, DRAIN_TIMEOUT=16.)
1. From reset, mode_request=010 held -> accepted after 2+4 cycles; switching=1, mode_select=000 for exactly 8 cycles; then mode_select=010, ready=1, no pulses.
2. In PWM (010), conv_busy=1, request 100 -> mode_select stays 010 while busy. Drop busy after 5 cycles -> 8 cycles of 000, then 100; drain_timeout never pulses.
3. In XADC (001), conv_busy held 1, request 010 -> drain_timeout pulses once on the 16th DRAIN cycle; then 000 for 8 cycles; then 010.
4. Glitch: mode_request toggles 001<->010 every 2 cycles for 40 cycles, then settles at 001 while current=001 -> no acceptance during toggling; state stays ACTIVE; mode_select constant 001.
5. Illegal request 110 held stable -> single bad_request pulse; mode_select/current unchanged. Request 101 during DRAIN -> pulse, target unaffected.
6. In DRAIN (busy=1) request reverts to current -> ACTIVE without OFF period. Separate run: reset asserted mid-SETTLE -> mode_select=000, ready=1 asynchronously; sequence restarts cleanly after release.
